// File: rtl/apb_pkg.sv
// Shared types for the APB completer: bus widths, FSM state encoding and the
// request captured during the setup phase.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 10;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic {IDLE, ACCESS} apb_slv_state_e;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB requester/completer signal bundle; clock and reset stay outside.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();
  logic                  selx;
  logic                  enable;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  slverr;

  modport slave  (input  selx, enable, write, addr, wdata,
                  output rdata, ready, slverr);
  modport master (output selx, enable, write, addr, wdata,
                  input  rdata, ready, slverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// Word register array: async clear, one synchronous write port, one
// combinational read port. Range checking is the caller's job.
module apb_slave_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a fixed wait-state count in front of a word register file.
// Setup values are latched so the requester cannot disturb a transfer in flight.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            resetn,
  apb_slave_mem_if.slave  bus
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  apb_slv_state_e        state, state_n;
  apb_req_t              req, req_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  ready_q, ready_n, slverr_q, slverr_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n, rf_rdata;
  logic                  setup, xfer, oob, wr_sel, rf_we;
  logic                  do_load, do_clear, do_count, resp;
  logic [ADDR_WIDTH-1:0] raddr;

  assign setup  = bus.selx & ~bus.enable;
  assign xfer   = bus.selx & bus.enable;
  // With zero wait states the response is built on the setup edge itself,
  // before the request has been latched, so look at the live bus then.
  assign raddr  = setup ? bus.addr  : req.addr[ADDR_WIDTH-1:0];
  assign wr_sel = setup ? bus.write : req.write;
  assign oob    = ({1'b0, raddr} >= DEPTH_L);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      req      <= '0;
      cnt      <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_n;
      req      <= req_n;
      cnt      <= cnt_n;
      ready_q  <= ready_n;
      slverr_q <= slverr_n;
      rdata_q  <= rdata_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (setup) state_n = ACCESS;
      ACCESS:  if (!bus.selx || (xfer && ready_q)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_n    = req;
    cnt_n    = cnt;
    ready_n  = ready_q;
    slverr_n = slverr_q;
    rdata_n  = rdata_q;
    do_load  = setup;
    do_clear = (state == ACCESS) && (!bus.selx || (xfer && ready_q));
    do_count = (state == ACCESS) && xfer && !ready_q;
    resp     = (do_load && (WAIT_CYCLES == 0)) || (do_count && (cnt == CNT_ONE));
    rf_we    = (state == ACCESS) && xfer && ready_q && req.write && !oob;
    if (do_load) begin
      req_n.addr  = APB_ADDR_WIDTH'(bus.addr);
      req_n.write = bus.write;
      req_n.wdata = APB_DATA_WIDTH'(bus.wdata);
      cnt_n       = CNT_LOAD;
      ready_n     = 1'b0;
      slverr_n    = 1'b0;
      rdata_n     = '0;
    end
    if (do_clear) begin
      cnt_n    = '0;
      ready_n  = 1'b0;
      slverr_n = 1'b0;
      rdata_n  = '0;
    end
    if (do_count) cnt_n = cnt - CNT_ONE;
    if (resp) begin
      ready_n  = 1'b1;
      slverr_n = oob;
      rdata_n  = (!wr_sel && !oob) ? rf_rdata : '0;
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_rf (
    .clk    (clk),
    .resetn (resetn),
    .we     (rf_we),
    .waddr  (req.addr[IDX_W-1:0]),
    .wdata  (req.wdata[DATA_WIDTH-1:0]),
    .raddr  (raddr[IDX_W-1:0]),
    .rdata  (rf_rdata)
  );

  assign bus.ready  = ready_q;
  assign bus.slverr = slverr_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (index 0 with no wait states,
// index 1 with two) checked against a per-instance array memory model.
module tb_apb_slave_mem;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        selx_d [2];
  logic        en_d   [2];
  logic        wr_d   [2];
  logic [9:0]  addr_d [2];
  logic [31:0] wdat_d [2];
  wire         rdy    [2];
  wire         err_o  [2];
  wire  [31:0] rdat_o [2];

  logic [31:0] mdl [2][256];

  apb_slave_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) if0 ();
  apb_slave_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) if1 ();

  assign if0.selx = selx_d[0]; assign if0.enable = en_d[0]; assign if0.write = wr_d[0];
  assign if0.addr = addr_d[0]; assign if0.wdata = wdat_d[0];
  assign if1.selx = selx_d[1]; assign if1.enable = en_d[1]; assign if1.write = wr_d[1];
  assign if1.addr = addr_d[1]; assign if1.wdata = wdat_d[1];
  assign rdy[0] = if0.ready; assign err_o[0] = if0.slverr; assign rdat_o[0] = if0.rdata;
  assign rdy[1] = if1.ready; assign err_o[1] = if1.slverr; assign rdat_o[1] = if1.rdata;

  apb_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  apb_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(2))
    dut1 (.clk(clk), .resetn(resetn), .bus(if1));

  function automatic int wt(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input bit wr, input logic [9:0] a);
    if (wr || a >= 10'd256) return 32'h0;
    return mdl[d][a[7:0]];
  endfunction

  task automatic mdl_update(input int d, input bit wr, input logic [9:0] a, input logic [31:0] wd);
    if (wr && a < 10'd256) mdl[d][a[7:0]] = wd;
  endtask

  task automatic mdl_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) mdl[d][i] = 32'h0;
  endtask

  task automatic idle(input int d);
    selx_d[d] = 1'b0; en_d[d] = 1'b0;
    @(negedge clk);
  endtask

  // One full transfer starting at a negedge; returns the sampled response,
  // number of ready=0 access cycles, total cycle count and ready after completion.
  task automatic do_xfer(input int d, input bit wr, input logic [9:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int waits,
                         output int cycles, output bit to, output logic rdy_after);
    int c0;
    c0 = cyc;
    selx_d[d] = 1'b1; en_d[d] = 1'b0; wr_d[d] = wr; addr_d[d] = a; wdat_d[d] = wd;
    @(posedge clk); @(negedge clk);
    en_d[d] = 1'b1;
    waits = 0; to = 1'b0;
    while (rdy[d] !== 1'b1) begin
      waits++;
      if (waits > 20) begin to = 1'b1; break; end
      @(negedge clk);
    end
    rd = rdat_o[d]; er = err_o[d];
    @(posedge clk); @(negedge clk);
    rdy_after = rdy[d];
    cycles = cyc - c0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, ra; int w, c; bit to;
    for (int d = 0; d < 2; d++) begin
      selx_d[d] = 0; en_d[d] = 0; wr_d[d] = 0; addr_d[d] = '0; wdat_d[d] = '0;
    end
    mdl_clear();
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rdy[d] !== 1'b0 || err_o[d] !== 1'b0 || rdat_o[d] !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs d=%0d got ready=%b slverr=%b rdata=%h exp 0/0/0",
                 d, rdy[d], err_o[d], rdat_o[d]);
      end
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_xfer(1, 0, 10'h007, 32'h0, rd, er, w, c, to, ra);
    total++;
    if (to || rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL reset_mem_clear d=1 got rdata=%h slverr=%b to=%0b exp 0", rd, er, to);
    end
    idle(1);
    do_xfer(0, 0, 10'h0ff, 32'h0, rd, er, w, c, to, ra);
    total++;
    if (to || rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL reset_mem_clear d=0 got rdata=%h slverr=%b to=%0b exp 0", rd, er, to);
    end
    idle(0);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, ra; int w, c; bit to;
    do_xfer(1, 1, 10'h005, 32'hDEADBEEF, rd, er, w, c, to, ra);
    mdl_update(1, 1, 10'h005, 32'hDEADBEEF);
    total++;
    if (to || w != 2 || er !== 1'b0 || rd !== 32'h0 || ra !== 1'b0) begin
      bad++; $display("FAIL wr_write got waits=%0d slverr=%b rdata=%h ready_after=%b exp 2/0/0/0", w, er, rd, ra);
    end
    idle(1);
    do_xfer(1, 0, 10'h005, 32'h0, rd, er, w, c, to, ra);
    total++;
    if (to || w != 2 || c != 4 || er !== 1'b0 || rd !== exp_rd(1, 0, 10'h005)) begin
      bad++; $display("FAIL wr_read got waits=%0d cycles=%0d slverr=%b rdata=%h exp 2/4/0/deadbeef", w, c, er, rd);
    end
    idle(1);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er, ra; int w, c; bit to;
    do_xfer(1, 1, 10'h100, 32'h12345678, rd, er, w, c, to, ra);
    total++;
    if (to || er !== 1'b1 || ra !== 1'b0) begin
      bad++; $display("FAIL oor_write got slverr=%b ready_after=%b to=%0b exp 1/0", er, ra, to);
    end
    idle(1);
    do_xfer(1, 0, 10'h100, 32'h0, rd, er, w, c, to, ra);
    total++;
    if (to || er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL oor_read got slverr=%b rdata=%h exp 1/00000000", er, rd);
    end
    idle(1);
    do_xfer(1, 0, 10'h000, 32'h0, rd, er, w, c, to, ra);
    total++;
    if (to || er !== 1'b0 || rd !== exp_rd(1, 0, 10'h000)) begin
      bad++; $display("FAIL oor_alias got slverr=%b rdata=%h exp 0/%h", er, rd, exp_rd(1, 0, 10'h000));
    end
    idle(1);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er, ra; int w, c, seen;
    bit to;
    selx_d[1] = 1; en_d[1] = 0; wr_d[1] = 1; addr_d[1] = 10'h010; wdat_d[1] = 32'hA5A5A5A5;
    @(posedge clk); @(negedge clk);
    selx_d[1] = 0; en_d[1] = 0;
    seen = 0;
    repeat (6) begin
      if (rdy[1] !== 1'b0) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL abort_ready got ready_cycles=%0d exp 0", seen);
    end
    do_xfer(1, 0, 10'h010, 32'h0, rd, er, w, c, to, ra);
    total++;
    if (to || rd !== exp_rd(1, 0, 10'h010) || er !== 1'b0) begin
      bad++; $display("FAIL abort_mem got rdata=%h slverr=%b exp %h/0", rd, er, exp_rd(1, 0, 10'h010));
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, v; logic er, ra; int w, c, seen, k;
    bit to;
    selx_d[1] = 1; en_d[1] = 0; wr_d[1] = 1; addr_d[1] = 10'h020; wdat_d[1] = $urandom;
    @(posedge clk); @(negedge clk);
    en_d[1] = 1;
    #1 resetn = 1'b0;
    #1;
    total++;
    if (rdy[1] !== 1'b0 || err_o[1] !== 1'b0 || rdat_o[1] !== 32'h0) begin
      bad++; $display("FAIL rstmid_wait got ready=%b slverr=%b rdata=%h exp 0", rdy[1], err_o[1], rdat_o[1]);
    end
    #1 resetn = 1'b1;
    mdl_clear();
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[1] !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rstmid_noresume got ready_cycles=%0d exp 0", seen);
    end
    idle(1);
    do_xfer(1, 0, 10'h020, 32'h0, rd, er, w, c, to, ra);
    total++;
    if (to || rd !== 32'h0) begin
      bad++; $display("FAIL rstmid_lost got rdata=%h exp 00000000", rd);
    end
    idle(1);
    v = $urandom | 32'h1;
    do_xfer(1, 1, 10'h021, v, rd, er, w, c, to, ra);
    mdl_update(1, 1, 10'h021, v);
    idle(1);
    selx_d[1] = 1; en_d[1] = 0; wr_d[1] = 0; addr_d[1] = 10'h021;
    @(posedge clk); @(negedge clk);
    en_d[1] = 1;
    k = 0;
    while (rdy[1] !== 1'b1 && k < 20) begin k++; @(negedge clk); end
    total++;
    if (rdy[1] !== 1'b1 || rdat_o[1] !== v) begin
      bad++; $display("FAIL rstmid_preread got ready=%b rdata=%h exp 1/%h", rdy[1], rdat_o[1], v);
    end
    #1 resetn = 1'b0;
    #1;
    total++;
    if (rdy[1] !== 1'b0 || err_o[1] !== 1'b0 || rdat_o[1] !== 32'h0) begin
      bad++; $display("FAIL rstmid_async got ready=%b slverr=%b rdata=%h exp 0", rdy[1], err_o[1], rdat_o[1]);
    end
    #1 resetn = 1'b1;
    mdl_clear();
    idle(1);
  endtask

  task automatic test_noise();
    logic [31:0] rd; logic er, ra; int w, c, seen, k;
    bit to;
    selx_d[1] = 1; en_d[1] = 1; wr_d[1] = 0; addr_d[1] = 10'h044;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy[1] !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL noise_nosetup got ready_cycles=%0d exp 0", seen);
    end
    idle(1);
    do_xfer(1, 1, 10'h030, 32'h11, rd, er, w, c, to, ra); mdl_update(1, 1, 10'h030, 32'h11); idle(1);
    do_xfer(1, 1, 10'h031, 32'h22, rd, er, w, c, to, ra); mdl_update(1, 1, 10'h031, 32'h22); idle(1);
    selx_d[1] = 1; en_d[1] = 0; wr_d[1] = 0; addr_d[1] = 10'h030;
    @(posedge clk); @(negedge clk);
    en_d[1] = 1; addr_d[1] = 10'h031; wr_d[1] = 1;
    k = 0;
    while (rdy[1] !== 1'b1 && k < 20) begin k++; @(negedge clk); end
    total++;
    if (rdy[1] !== 1'b1 || rdat_o[1] !== exp_rd(1, 0, 10'h030) || err_o[1] !== 1'b0) begin
      bad++; $display("FAIL noise_addr_change got ready=%b rdata=%h exp 1/%h", rdy[1], rdat_o[1], exp_rd(1, 0, 10'h030));
    end
    @(posedge clk); @(negedge clk);
    idle(1);
    do_xfer(1, 0, 10'h031, 32'h0, rd, er, w, c, to, ra);
    total++;
    if (to || rd !== exp_rd(1, 0, 10'h031)) begin
      bad++; $display("FAIL noise_no_write got rdata=%h exp %h", rd, exp_rd(1, 0, 10'h031));
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, e; logic er, ra; int w, c, errs;
    bit to;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      do_xfer(0, 1, 10'(i), 32'(i) * 32'h11, rd, er, w, c, to, ra);
      mdl_update(0, 1, 10'(i), 32'(i) * 32'h11);
      if (to || w != 0 || c != 2 || er !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL b2b_writes got bad_transfers=%0d exp 0", errs);
    end
    for (int i = 0; i < 8; i++) begin
      do_xfer(0, 0, 10'(i), 32'h0, rd, er, w, c, to, ra);
      e = 32'(i) * 32'h11;
      total++;
      if (to || w != 0 || c != 2 || er !== 1'b0 || rd !== e) begin
        bad++; $display("FAIL b2b_read%0d got rdata=%h waits=%0d cycles=%0d exp %h/0/2", i, rd, w, c, e);
      end
    end
    idle(0);
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, er_d; logic er, ra, eerr; int w, c, d;
    bit wr, to;
    logic [9:0] a;
    for (int i = 0; i < 40; i++) begin
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(250, 265)) : 10'($urandom_range(0, 15));
      wd = $urandom;
      er_d = exp_rd(d, wr, a);
      eerr = (a >= 10'd256);
      do_xfer(d, wr, a, wd, rd, er, w, c, to, ra);
      total++;
      if (to || rd !== er_d || er !== eerr || c != wt(d) + 2 || ra !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d d=%0d wr=%0b a=%h got rdata=%h slverr=%b cycles=%0d exp %h/%b/%0d",
                 i, d, wr, a, rd, er, c, er_d, eerr, wt(d) + 2);
      end
      if (!to) mdl_update(d, wr, a, wd);
      if ($urandom_range(0, 1) == 1 || to) idle(d);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_noise();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer: the responder end of the APB interface our protocol checker monitors.
- Decodes setup/access phases from a requester, holds a word-addressed register memory, and inserts a fixed number of wait states.
- Returns ready, rdata and slverr; addresses at or beyond MEM_DEPTH are rejected with slverr.
- Intended as the DUT-side completer for the APB environment and as a reusable peripheral register block.

Parameters:
- ADDR_WIDTH, 10, word address width.
- DATA_WIDTH, 32, data bus width.
- MEM_DEPTH, 256, number of implemented words; legal addr range is 0..MEM_DEPTH-1, with MEM_DEPTH <= 2**ADDR_WIDTH.
- WAIT_CYCLES, 2, number of ACCESS cycles with ready=0 before ready=1; 0 is legal and means no wait.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- selx  in  1  peripheral select.
- enable  in  1  access-phase strobe.
- write  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data, valid when ready=1 and the latched write=0.
- ready  out  1  transfer completes on the edge where selx&enable&ready=1.
- slverr  out  1  error response, qualified by ready.

Behaviour:
- Reset (async, resetn=0): state=IDLE, ready=0, slverr=0, rdata=0, wait counter=0, all memory words=0. All outputs are registered.
- FSM states are IDLE and ACCESS.
- IDLE:
  - On an edge sampling selx=1 and enable=0 (setup), latch addr, write and wdata, then go to ACCESS.
  - Load counter=WAIT_CYCLES.
  - Set ready <= (WAIT_CYCLES==0).
  - selx=1 with enable=1 while in IDLE (no setup) is ignored: no response, stay IDLE.
- ACCESS, ready=0, selx&enable=1: decrement counter. When counter==1, set ready<=1 so that ready is high in ACCESS cycle WAIT_CYCLES+1.
- Response values are registered on the same edge that sets ready=1:
  - slverr <= (latched addr >= MEM_DEPTH).
  - On a read: rdata <= mem[latched addr] if in range, else 0.
  - On a write: rdata stays 0.
- Completion is the edge with selx&enable&ready=1:
  - Write and no error: mem[latched addr] <= latched wdata.
  - Out-of-range write: discarded.
  - Next state: ready<=0, slverr<=0, rdata<=0, state->IDLE.
  - If that same edge also samples a new setup (selx=1, enable=0), that cannot occur because enable=1. The next setup is taken on the following edge, so back-to-back transfers cost no extra idle cycle.
- Requester changes addr/write/wdata during ACCESS: ignored. Latched setup values are used, so behaviour is deterministic under protocol violations.
- Abort (selx=0 sampled in ACCESS): state->IDLE; ready, slverr and rdata cleared; no memory update.
- selx=1 with enable=0 sampled while in ACCESS (requester restarted setup): treated as a new setup. Relatch, reload counter, previous transfer dropped.
- Reset asserted mid-transfer: immediate return to reset values; a pending write is lost.
- Invariants:
  - ready=1 only in ACCESS.
  - slverr=1 only with ready=1.
  - rdata and slverr never X after reset.
- Throughput: one transfer per WAIT_CYCLES+2 cycles, counting setup and access.

Decomposition:
- Package apb_pkg holds:
  - Constants APB_ADDR_WIDTH=10 and APB_DATA_WIDTH=32.
  - typedef enum logic {IDLE, ACCESS} apb_slv_state_e.
  - typedef struct {addr, write, wdata} apb_req_t for the latched request.
- Sub-module apb_slave_regfile: MEM_DEPTH x DATA_WIDTH array, async clear on resetn, synchronous write port (we, waddr, wdata), combinational read port (raddr, rdata). The FSM, counter and response logic stay in apb_slave_mem.

Test Plan:
- Write then read, WAIT_CYCLES=2. Write addr=0x005, wdata=0xDEADBEEF, then read addr=0x005 -> ready low for 2 ACCESS cycles and high on the 3rd for each transfer; read returns rdata=0xDEADBEEF, slverr=0.
- WAIT_CYCLES=0, 8 back-to-back writes to 0..7 (data=addr*0x11) then 8 reads -> ready=1 on the first ACCESS cycle every time; every read matches; each transfer takes exactly 2 cycles.
- Out-of-range access at addr=0x100 (MEM_DEPTH=256). Write 0x12345678 -> slverr=1 with ready. Read 0x100 -> rdata=0, slverr=1. Then read 0x000 -> 0x00000000, proving nothing was aliased.
- Abort: setup a write to 0x010 with wdata=0xA5A5A5A5, drop selx in the first ACCESS cycle -> ready never rises; a subsequent read of 0x010 returns 0.
- Reset mid-access: write to 0x020 and pulse resetn low during a wait cycle -> ready, slverr and rdata go 0 asynchronously; a later read of 0x020 returns 0.
- Protocol noise: enable=1 without setup -> no ready within 10 cycles. addr changed to 0x031 during ACCESS of a read to 0x030, with mem[0x030]=0x11, mem[0x031]=0x22 -> rdata=0x11.
